sub_bytes_engine: RTL and testbench

//   Multi-cycle, area-scaled AES byte-substitution unit serving both encrypt
//   (SubBytes) and decrypt (InvSubBytes) datapaths. Accepts a 128-bit state

---
 rtl/sub_bytes_engine.sv | 118 +++++++++++
 tb/tb_sub_bytes_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// AES SubBytes / InvSubBytes unit: substitutes LANES bytes per cycle over CYCLES
// cycles with valid/ready handshakes on both sides.
module sub_bytes_engine #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic         inv_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   localparam int unsigned CYCLES = 16 / LANES;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] FWD_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   logic [1:0] state;
   logic [3:0] cnt;
   logic       mode;
   logic       accept;
   logic       last;
   logic [3:0] lane_idx [LANES];
   logic [7:0] lane_sub [LANES];

   // Each lane reads its byte from the work register in place; one shared table pair per lane.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] lane_in;
      assign lane_idx[l] = 4'((32'(cnt) * LANES) + l);
      assign lane_in     = data_out[{lane_idx[l], 3'b000} +: 8];
      assign lane_sub[l] = mode ? INV_SBOX[lane_in] : FWD_SBOX[lane_in];
   end

   assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid & in_ready;
   assign last      = (cnt == 4'(CYCLES - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         mode     <= 1'b0;
         data_out <= '0;
      end else if (accept) begin
         data_out <= data_in;
         mode     <= inv_mode;
         cnt      <= '0;
         state    <= S_BUSY;
      end else begin
         case (state)
            S_BUSY: begin
               for (int unsigned l = 0; l < LANES; l++) begin
                  data_out[{lane_idx[l], 3'b000} +: 8] <= lane_sub[l];
               end
               if (last) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine at LANES = 4, 1 and 16: directed vectors,
// latency, backpressure, mid-operation reset and back-to-back streaming.
module tb_sub_bytes_engine;

   localparam logic [127:0] V1  = 128'h5d7456657b536f65735b47726374545d;
   localparam logic [127:0] V2  = 128'h8dcab9bc035006bc8f57161e00cafd8d;
   localparam logic [127:0] Z   = '0;
   localparam logic [127:0] F63 = {16{8'h63}};
   localparam logic [127:0] I52 = {16{8'h52}};
   localparam int unsigned LAT  [3] = '{4, 16, 1};
   localparam int unsigned IVL  [3] = '{5, 17, 2};

   logic         clk = 1'b0;
   logic         n_rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         inv_mode  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] data_in   [3];
   logic [127:0] data_out  [3];
   logic [127:0] sb [3][$];
   int unsigned  checks = 0;
   int unsigned  errors = 0;
   int unsigned  cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sub_bytes_engine #(.LANES(4)) u_l4 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .data_in(data_in[0]), .inv_mode(inv_mode[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .data_out(data_out[0]));

   sub_bytes_engine #(.LANES(1)) u_l1 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .data_in(data_in[1]), .inv_mode(inv_mode[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .data_out(data_out[1]));

   sub_bytes_engine #(.LANES(16)) u_l16 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .data_in(data_in[2]), .inv_mode(inv_mode[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .data_out(data_out[2]));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Completed blocks are popped from the scoreboard on each output handshake.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (n_rst === 1'b1 && out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
            if (sb[i].size() == 0)
               chk($sformatf("unexpected_out_%0d", i), 128'(sb[i].size()), 128'd1);
            else
               chk($sformatf("result_%0d", i), data_out[i], sb[i].pop_front());
         end
      end
   end

   task automatic send(input int i, input logic [127:0] d, input logic m,
                       input logic [127:0] e, input bit push);
      @(posedge clk); #1;
      in_valid[i] = 1'b1;
      data_in[i]  = d;
      inv_mode[i] = m;
      if (push) sb[i].push_back(e);
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      data_in[i]  = ~d;
      inv_mode[i] = ~m;
   endtask

   task automatic wait_valid(input int i, output int unsigned n);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (out_valid[i] === 1'b1) break;
      end
   endtask

   task automatic run_one(input int i, input logic [127:0] d, input logic m,
                          input logic [127:0] e, input string tag);
      int unsigned n;
      send(i, d, m, e, 1'b1);
      wait_valid(i, n);
      chk($sformatf("%s_lat_%0d", tag, i), 128'(n), 128'(LAT[i]));
      @(posedge clk); #1;
      chk($sformatf("%s_retire_%0d", tag, i), 128'(out_valid[i]), 128'd0);
   endtask

   task automatic b2b(input int i);
      int unsigned last_cyc = 0;
      int unsigned n;
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin
         in_valid[i] = 1'b1;
         data_in[i]  = (j % 2 == 0) ? V1 : V2;
         inv_mode[i] = (j % 2 == 0);
         sb[i].push_back((j % 2 == 0) ? V2 : V1);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (in_ready[i] !== 1'b1 && n < 40);
         @(posedge clk); #1;
         if (j > 0) chk($sformatf("b2b_interval_%0d_%0d", i, j), 128'(cyc - last_cyc), 128'(IVL[i]));
         last_cyc = cyc;
      end
      in_valid[i] = 1'b0;
      n = 0;
      while (sb[i].size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("b2b_drained_%0d", i), 128'(sb[i].size()), 128'd0);
   endtask

   initial begin
      int unsigned n;
      n_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         data_in[i]   = '0;
         inv_mode[i]  = 1'b0;
         out_ready[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_in_ready_%0d", i), 128'(in_ready[i]), 128'd1);
         chk($sformatf("rst_out_valid_%0d", i), 128'(out_valid[i]), 128'd0);
         chk($sformatf("rst_data_out_%0d", i), data_out[i], Z);
      end
      n_rst = 1'b1;

      for (int i = 0; i < 3; i++) begin
         run_one(i, V1, 1'b1, V2, "inv_vec");
         run_one(i, V2, 1'b0, V1, "fwd_vec");
      end
      run_one(0, Z, 1'b0, F63, "zero_fwd");
      run_one(0, Z, 1'b1, I52, "zero_inv");

      // Held result under backpressure while a new request is presented.
      out_ready[0] = 1'b0;
      send(0, V2, 1'b0, V1, 1'b1);
      wait_valid(0, n);
      chk("bp_lat", 128'(n), 128'(LAT[0]));
      in_valid[0] = 1'b1;
      data_in[0]  = Z;
      inv_mode[0] = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
         chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
         chk("bp_data_out", data_out[0], V1);
      end
      sb[0].push_back(I52);
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      wait_valid(0, n);
      chk("bp_next_lat", 128'(n), 128'(LAT[0]));
      @(posedge clk); #1;

      // Reset two cycles into a block aborts it.
      send(0, V1, 1'b1, Z, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("midrst_data_out", data_out[0], Z);
      chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
      @(posedge clk); #1;
      n_rst = 1'b1;
      run_one(0, Z, 1'b0, F63, "post_rst");

      b2b(1);
      b2b(2);

      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("sb_empty_%0d", i), 128'(sb[i].size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
